// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: issues sequential word fetches to a
// one-cycle-latency instruction memory and buffers responses in a small
// FIFO in front of decode. Redirects and reset flush the queue and drop
// any response still in flight.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PW = $clog2(QUEUE_DEPTH);   // pointer width
    localparam int CW = PW + 1;                // count width (holds 0..DEPTH)
    localparam int OW = PW + 2;                // occupancy width (count + inflight)

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   inst_mem_q [QUEUE_DEPTH];
    logic [31:0]   pc_mem_q   [QUEUE_DEPTH];

    logic          pop;
    logic          push;
    logic [OW-1:0] occupancy;

    // Handshake and issue decisions; the head is visible only while the
    // queue holds data, so a response arriving into an empty queue waits a cycle.
    always_comb begin
        inst_valid = !reset && (count_q != '0);
        pop        = inst_valid && inst_ready;
        // A response is dropped if a redirect or reset lands in its arrival cycle.
        push       = inflight_q && !redirect_valid && !reset;
        // Slots that will be committed once this cycle's pop retires; a new
        // fetch is only issued if its response is guaranteed a free slot.
        occupancy  = OW'(count_q) + OW'(inflight_q) - OW'(pop);
        imem_req   = !reset && !redirect_valid && (occupancy < OW'(QUEUE_DEPTH));
    end

    assign imem_addr = fetch_pc_q;
    assign inst      = inst_mem_q[rd_ptr_q];
    assign inst_pc   = pc_mem_q[rd_ptr_q];

    // Next-state for fetch PC, in-flight tracking and queue pointers.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect_valid) begin
            // Low address bits of the target are ignored to keep fetches aligned.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage: data only, validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    // The issue rule must make a push into a full, non-popping queue impossible.
    assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == CW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: two instances (default reset PC and a reset PC
// near the top of the address space) fed by a memory model that returns the
// requested word address as data. Expected PCs are queued when a stream is
// started and compared as decode pops the queue head.
module tb_imem_fetch_ctrl;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        a_reset, a_req, a_redir_valid, a_inst_valid, a_ready;
    logic [31:0] a_addr, a_rdata, a_redir_pc, a_inst, a_inst_pc;
    // Instance B signals
    logic        b_reset, b_req, b_redir_valid, b_inst_valid, b_ready;
    logic [31:0] b_addr, b_rdata, b_redir_pc, b_inst, b_inst_pc;

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(a_reset), .imem_req(a_req), .imem_addr(a_addr),
        .imem_rdata(a_rdata), .redirect_valid(a_redir_valid), .redirect_pc(a_redir_pc),
        .inst_valid(a_inst_valid), .inst(a_inst), .inst_pc(a_inst_pc), .inst_ready(a_ready)
    );

    imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(b_reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_rdata(b_rdata), .redirect_valid(b_redir_valid), .redirect_pc(b_redir_pc),
        .inst_valid(b_inst_valid), .inst(b_inst), .inst_pc(b_inst_pc), .inst_ready(b_ready)
    );

    // Memory model: data for the address presented in one cycle appears in the next.
    always @(posedge clk) begin
        a_rdata <= a_addr;
        b_rdata <= b_addr;
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic void restart_a(input logic [31:0] start, input int n);
        exp_a.delete();
        for (int i = 0; i < n; i++) exp_a.push_back(start + 32'(4 * i));
    endfunction

    function automatic void restart_b(input logic [31:0] start, input int n);
        exp_b.delete();
        for (int i = 0; i < n; i++) exp_b.push_back(start + 32'(4 * i));
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Let combinational outputs settle, then score any handshake this cycle.
    task automatic observe();
        logic [31:0] e;
        #1;
        if (a_inst_valid && a_ready) begin
            check32("a_sb_expected_entry", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                $display("A pop pc=%08h inst=%08h exp=%08h", a_inst_pc, a_inst, e);
                check32("a_inst_pc", a_inst_pc, e);
                check32("a_inst", a_inst, e);
            end
        end
        if (b_inst_valid && b_ready) begin
            check32("b_sb_expected_entry", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                $display("B pop pc=%08h inst=%08h exp=%08h", b_inst_pc, b_inst, e);
                check32("b_inst_pc", b_inst_pc, e);
                check32("b_inst", b_inst, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset = 1'b1; a_ready = 1'b0; a_redir_valid = 1'b0; a_redir_pc = '0;
        b_reset = 1'b1; b_ready = 1'b0; b_redir_valid = 1'b0; b_redir_pc = '0;

        // Reset state
        repeat (3) begin
            cyc();
            observe();
        end
        check32("rst_req", 32'(a_req), 32'd0);
        check32("rst_valid", 32'(a_inst_valid), 32'd0);
        check32("rst_addr", a_addr, 32'h0);
        check32("rst_b_addr", b_addr, 32'hFFFF_FFF8);

        // Free running from reset: one fetch and, from the third cycle, one pop per cycle
        restart_a(32'h0, 64);
        for (int k = 0; k <= 12; k++) begin
            cyc();
            a_reset = 1'b0; a_ready = 1'b1;
            observe();
            check32("run_addr", a_addr, 32'(4 * k));
            check32("run_req", 32'(a_req), 32'd1);
            check32("run_valid", 32'(a_inst_valid), 32'(k >= 2));
        end

        // Decode stalled for 10 cycles: queue fills and fetching stops
        for (int k = 0; k < 10; k++) begin
            cyc();
            a_ready = 1'b0;
            observe();
            check32("stall_req", 32'(a_req), 32'd0);
        end
        check32("stall_valid", 32'(a_inst_valid), 32'd1);
        check32("stall_count", 32'(dut_a.count_q), 32'(DEPTH));
        check32("stall_head", a_inst_pc, exp_a[0]);
        for (int k = 0; k < 8; k++) begin
            cyc();
            a_ready = 1'b1;
            observe();
            check32("release_valid", 32'(a_inst_valid), 32'd1);
        end

        // Redirect to an unaligned target while the queue is full
        for (int k = 0; k < 4; k++) begin
            cyc();
            a_ready = 1'b0;
            observe();
        end
        cyc();
        a_redir_valid = 1'b1; a_redir_pc = 32'h0000_0103;
        observe();
        check32("redir_req_t", 32'(a_req), 32'd0);
        restart_a(32'h100, 32);
        cyc();
        a_redir_valid = 1'b0; a_ready = 1'b1;
        observe();
        check32("redir_req_t1", 32'(a_req), 32'd1);
        check32("redir_addr_t1", a_addr, 32'h100);
        check32("redir_valid_t1", 32'(a_inst_valid), 32'd0);
        cyc();
        observe();
        check32("redir_valid_t2", 32'(a_inst_valid), 32'd0);
        cyc();
        observe();
        check32("redir_valid_t3", 32'(a_inst_valid), 32'd1);
        check32("redir_pc_t3", a_inst_pc, 32'h100);
        repeat (4) begin
            cyc();
            observe();
        end

        // Back-to-back redirects, with a pop in the first redirect cycle
        cyc();
        a_redir_valid = 1'b1; a_redir_pc = 32'h40;
        observe();
        check32("rr_req_t", 32'(a_req), 32'd0);
        exp_a.delete();
        cyc();
        a_redir_pc = 32'h80;
        observe();
        check32("rr_req_t1", 32'(a_req), 32'd0);
        check32("rr_valid_t1", 32'(a_inst_valid), 32'd0);
        restart_a(32'h80, 32);
        cyc();
        a_redir_valid = 1'b0;
        observe();
        check32("rr_req_t2", 32'(a_req), 32'd1);
        check32("rr_addr_t2", a_addr, 32'h80);
        check32("rr_valid_t2", 32'(a_inst_valid), 32'd0);
        cyc();
        observe();
        check32("rr_valid_t3", 32'(a_inst_valid), 32'd0);
        cyc();
        observe();
        check32("rr_valid_t4", 32'(a_inst_valid), 32'd1);
        check32("rr_pc_t4", a_inst_pc, 32'h80);
        repeat (6) begin
            cyc();
            observe();
        end

        // One-cycle reset pulse with a response in flight
        cyc();
        a_reset = 1'b1;
        observe();
        check32("rp_req_t", 32'(a_req), 32'd0);
        check32("rp_valid_t", 32'(a_inst_valid), 32'd0);
        restart_a(32'h0, 32);
        cyc();
        a_reset = 1'b0;
        observe();
        check32("rp_req_t1", 32'(a_req), 32'd1);
        check32("rp_addr_t1", a_addr, 32'h0);
        check32("rp_valid_t1", 32'(a_inst_valid), 32'd0);
        cyc();
        observe();
        check32("rp_valid_t2", 32'(a_inst_valid), 32'd0);
        cyc();
        observe();
        check32("rp_valid_t3", 32'(a_inst_valid), 32'd1);
        check32("rp_pc_t3", a_inst_pc, 32'h0);
        repeat (4) begin
            cyc();
            observe();
        end

        // Fetch PC wrapping past the top of the address space
        restart_b(32'hFFFF_FFF8, 16);
        for (int k = 0; k <= 6; k++) begin
            cyc();
            b_reset = 1'b0; b_ready = 1'b1;
            observe();
            check32("wrap_addr", b_addr, 32'hFFFF_FFF8 + 32'(4 * k));
            check32("wrap_valid", 32'(b_inst_valid), 32'(k >= 2));
            if (k == 4) check32("wrap_pc_zero", b_inst_pc, 32'h0000_0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter QUEUE_DEPTH, default 2, meaning the instruction queue depth; legal values are powers of 2 and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: a fetch is issued this cycle.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: fetch address, word aligned.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction data, valid exactly one cycle after the imem_req cycle.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect strobe.
REQ-009 The block SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-010 The block SHALL have port inst_valid, output, 1 bit: the queue head is valid.
REQ-011 The block SHALL have port inst, output, 32 bits: the queue head instruction.
REQ-012 The block SHALL have port inst_pc, output, 32 bits: the queue head PC.
REQ-013 The block SHALL have port inst_ready, input, 1 bit: the decode stage accepts the queue head.

Function
REQ-014 The block SHALL hold a fetch_pc register; imem_addr SHALL equal fetch_pc in every cycle.
REQ-015 The block SHALL define pop as inst_valid && inst_ready in the same cycle.
REQ-016 imem_req SHALL be 1 iff reset=0, redirect_valid=0, and (count + inflight - pop) < QUEUE_DEPTH.
- count: number of queue entries.
- inflight: 1 if imem_req was issued in the previous cycle and not squashed.
REQ-017 On an issue, fetch_pc SHALL advance by 4, mod 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-018 The cycle after an unsquashed issue, {imem_rdata, issued PC} SHALL be pushed at the queue tail.
REQ-019 The queue SHALL be FIFO; inst and inst_pc SHALL be driven from the head; inst_valid SHALL equal (count != 0).
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve order, including when count = QUEUE_DEPTH.
REQ-021 The queue SHALL never overflow; a push with count = QUEUE_DEPTH and no pop is a design error, flagged by an assertion.
REQ-022 Steady-state throughput SHALL be one instruction per cycle while inst_ready=1 and there is no redirect.
REQ-023 On redirect_valid=1 at cycle t, the block SHALL:
- set fetch_pc to {redirect_pc[31:2], 2'b00}, ignoring redirect_pc[1:0];
- clear the queue (count := 0);
- squash any inflight response, which SHALL not be pushed at t+1;
- drive imem_req=0 at t.
REQ-024 A pop in a redirect cycle SHALL complete as a normal handshake, and the queue SHALL still be fully cleared.
REQ-025 Redirect-to-use latency SHALL be as follows, with no bypass from imem_rdata to inst:
- imem_req for the target at t+1;
- target pushed at the end of t+2;
- inst_valid=1 with inst_pc = target at t+3.
REQ-026 Redirects on consecutive cycles SHALL each take effect; only the last target is fetched.
REQ-027 inst_valid SHALL be 0 when count = 0, even if a response arrives that cycle.

Reset
REQ-028 While reset=1, the block SHALL hold imem_req=0, inst_valid=0, count=0, inflight=0, and fetch_pc=RESET_PC; inst and inst_pc are don't-care.
REQ-029 In the first cycle with reset=0, imem_req SHALL be 1 with imem_addr=RESET_PC, and inst_valid SHALL rise two cycles later.
REQ-030 Reset asserted mid-operation SHALL discard queue contents and any inflight response, with no push in the cycle after reset deasserts unless a new issue occurred.

Verification
REQ-031 Bench SHALL cover: reset deassert, inst_ready=1, memory returning word address as data -> imem_addr 0,4,8,...; inst_pc 0,4,8,... one per cycle from the third cycle.
REQ-032 Bench SHALL cover: inst_ready=0 for 10 cycles -> exactly QUEUE_DEPTH entries held, imem_req=0, no lost or duplicated PCs on release.
REQ-033 Bench SHALL cover: redirect_valid with redirect_pc=32'h0000_0103 while the queue is full -> queue cleared; imem_req to 32'h100 next cycle; inst_pc=32'h100 three cycles after redirect.
REQ-034 Bench SHALL cover: redirects in two consecutive cycles to 32'h40 then 32'h80 -> no instruction from 32'h40 or the old stream ever reaches inst_valid.
REQ-035 Bench SHALL cover: RESET_PC=32'hFFFF_FFF8, free running -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Bench SHALL cover: reset pulsed for one cycle mid-stream with inflight=1 -> inst_valid=0 until the new stream from RESET_PC arrives; no stale instruction is delivered.
